bus_rr_sched: RTL

Round-robin scheduler that owns the shared bus between drvrs source FIFOs and drvrs destination ports.
- Arbitrates among sources with pending packets and pops exactly one packet from the granted source.
- Decodes the 8-bit destination ID in the packet header.
- Pushes the packet to one destination, or to all destinations except the source on broadcast.
- Sits between the per-driver source FIFOs (pndng/pop/D_pop) and the destination ports (push/D_push) in the bus generator.

---
 rtl/bus_rr_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: pops one packet per grant from the source FIFOs and pushes it to one or all destinations.
// Optional statistics counters (pkt_cnt, drop_cnt) are enabled by defining BUS_RR_SCHED_STATS_EN.
module bus_rr_sched #(
   parameter int          drvrs     = 4,
   parameter int          pckg_sz   = 16,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic [drvrs-1:0]           grant,
   output logic                       busy,
   output logic                       drop
`ifdef BUS_RR_SCHED_STATS_EN
   ,
   output logic [31:0]                pkt_cnt,
   output logic [15:0]                drop_cnt
`endif
);

   // state | meaning
   // IDLE  | no source pending, bus free
   // GRANT | source gnt_idx granted; pop it if still pending
   // PUSH  | drive popped packet to destination(s), re-arbitrate
   typedef enum logic [1:0] {IDLE, GRANT, PUSH} state_t;

   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
   localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

   state_t              state;
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       gnt_idx;
   logic [IW-1:0]       arb_idx;
   logic                arb_found;
   int                  arb_j;
   logic [pckg_sz-1:0]  pkt_reg;
   logic [7:0]          id;

   assign id = pkt_reg[pckg_sz-1 -: 8];

   // Cyclic search starting just after the last served source; that source is checked last.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = last_grant;
      arb_j     = 0;
      for (int k = 1; k <= drvrs; k++) begin
         arb_j = int'(last_grant) + k;
         if (arb_j >= drvrs) arb_j = arb_j - drvrs;
         if (!arb_found && pndng[IW'(arb_j)]) begin
            arb_found = 1'b1;
            arb_idx   = IW'(arb_j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= IW'(drvrs - 1);
         gnt_idx    <= '0;
         pkt_reg    <= '0;
         pop        <= '0;
         push       <= '0;
         D_push     <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         drop       <= 1'b0;
`ifdef BUS_RR_SCHED_STATS_EN
         pkt_cnt    <= '0;
         drop_cnt   <= '0;
`endif
      end else begin
         pop  <= '0;
         push <= '0;
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  state   <= GRANT;
                  gnt_idx <= arb_idx;
                  grant   <= ONE << arb_idx;
                  busy    <= 1'b1;
               end
            end
            GRANT: begin
               if (pndng[gnt_idx]) begin
                  pop        <= grant;
                  pkt_reg    <= D_pop[int'(gnt_idx)*pckg_sz +: pckg_sz];
                  last_grant <= gnt_idx;
                  state      <= PUSH;
               end else begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            PUSH: begin
               if (id == broadcast) begin
                  push   <= ~(ONE << gnt_idx);
                  D_push <= pkt_reg;
`ifdef BUS_RR_SCHED_STATS_EN
                  if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
`endif
               end else if (int'(id) < drvrs) begin
                  push   <= ONE << id;
                  D_push <= pkt_reg;
`ifdef BUS_RR_SCHED_STATS_EN
                  if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
`endif
               end else begin
                  drop <= 1'b1;
`ifdef BUS_RR_SCHED_STATS_EN
                  if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
`endif
               end
               // The just-served source is searched last; GRANT rechecks it in case the pop emptied it.
               if (arb_found) begin
                  state   <= GRANT;
                  gnt_idx <= arb_idx;
                  grant   <= ONE << arb_idx;
               end else begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
